// File: rtl/decode_pkg.sv
// Shared RV32I decode constants: opcodes, one-hot class and exception bit positions,
// system funct12 codes and the immediate format selector.
package decode_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam int NUM_CLS    = 11;
  localparam int CLS_R      = 0;
  localparam int CLS_I      = 1;
  localparam int CLS_LOAD   = 2;
  localparam int CLS_STORE  = 3;
  localparam int CLS_BRANCH = 4;
  localparam int CLS_JAL    = 5;
  localparam int CLS_JALR   = 6;
  localparam int CLS_LUI    = 7;
  localparam int CLS_AUIPC  = 8;
  localparam int CLS_SYSTEM = 9;
  localparam int CLS_FENCE  = 10;

  localparam int EXC_ILLEGAL = 0;
  localparam int EXC_ECALL   = 1;
  localparam int EXC_EBREAK  = 2;
  localparam int EXC_MRET    = 3;

  localparam logic [11:0] F12_ECALL  = 12'h000;
  localparam logic [11:0] F12_EBREAK = 12'h001;
  localparam logic [11:0] F12_MRET   = 12'h302;

  // Classes that read rs1 / rs2, used by the load-use interlock.
  localparam logic [NUM_CLS-1:0] RS1_USERS = NUM_CLS'((1 << CLS_R) | (1 << CLS_I) | (1 << CLS_LOAD) |
                                                      (1 << CLS_STORE) | (1 << CLS_BRANCH) | (1 << CLS_JALR));
  localparam logic [NUM_CLS-1:0] RS2_USERS = NUM_CLS'((1 << CLS_R) | (1 << CLS_STORE) | (1 << CLS_BRANCH));

  typedef enum logic [2:0] {FMT_NONE, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} imm_fmt_e;

endpackage

// File: rtl/ds_instr_queue.sv
// Circular instruction FIFO: push ignored when full or flushing, pop ignored when empty.
// Head data is read combinationally; count/full/empty come straight from registers.
module ds_instr_queue #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [WIDTH-1:0]           wdat_i,
  output logic [WIDTH-1:0]           rdat_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign rdat_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (do_push && !do_pop)      count_q <= count_q + CW'(1);
      else if (!do_push && do_pop) count_q <= count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdat_i;
  end

endmodule

// File: rtl/decode_queue_stage.sv
// Queued RV32I decode stage: push-to-output latency 2 edges, ds_o_stall while the queue is full.
// Define DS_LOAD_USE_EN to hold the head for one bubble when it reads a load's destination.
module decode_queue_stage #(
  parameter int PC_WIDTH = 32,
  parameter int IWIDTH   = 32,
  parameter int DWIDTH   = 32,
  parameter int AWIDTH   = 5,
  parameter int DEPTH    = 4
) (
  input  logic                       ds_clk,
  input  logic                       ds_rst,
  input  logic [IWIDTH-1:0]          ds_i_instr,
  input  logic [PC_WIDTH-1:0]        ds_i_pc,
  input  logic                       ds_i_ce,
  input  logic                       ds_i_stall,
  input  logic                       ds_i_flush,
  output logic                       ds_o_stall,
  output logic                       ds_o_flush,
  output logic                       ds_o_ce,
  output logic [PC_WIDTH-1:0]        ds_o_pc,
  output logic [AWIDTH-1:0]          ds_o_addr_rs1_p,
  output logic [AWIDTH-1:0]          ds_o_addr_rs2_p,
  output logic [AWIDTH-1:0]          ds_o_addr_rd_p,
  output logic [2:0]                 ds_o_funct3,
  output logic                       ds_o_funct7_b5,
  output logic [DWIDTH-1:0]          ds_o_imm,
  output logic [10:0]                ds_o_opcode,
  output logic [3:0]                 ds_o_exception,
  output logic [$clog2(DEPTH+1)-1:0] ds_o_count
);
  import decode_pkg::*;

  typedef struct packed {
    logic [NUM_CLS-1:0] cls;
    logic [3:0]         exc;
    logic [31:0]        imm;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] ins);
    dec_t     d;
    imm_fmt_e fmt;
    d   = '0;
    fmt = FMT_NONE;
    case (ins[6:0])
      OPC_OP:     d.cls[CLS_R] = 1'b1;
      OPC_OP_IMM: begin d.cls[CLS_I]      = 1'b1; fmt = FMT_I; end
      OPC_LOAD:   begin d.cls[CLS_LOAD]   = 1'b1; fmt = FMT_I; end
      OPC_STORE:  begin d.cls[CLS_STORE]  = 1'b1; fmt = FMT_S; end
      OPC_BRANCH: begin d.cls[CLS_BRANCH] = 1'b1; fmt = FMT_B; end
      OPC_JAL:    begin d.cls[CLS_JAL]    = 1'b1; fmt = FMT_J; end
      OPC_JALR:   begin d.cls[CLS_JALR]   = 1'b1; fmt = FMT_I; end
      OPC_LUI:    begin d.cls[CLS_LUI]    = 1'b1; fmt = FMT_U; end
      OPC_AUIPC:  begin d.cls[CLS_AUIPC]  = 1'b1; fmt = FMT_U; end
      OPC_FENCE:  d.cls[CLS_FENCE] = 1'b1;
      OPC_SYSTEM: begin
        d.cls[CLS_SYSTEM] = 1'b1;
        if (ins[14:12] != 3'b000) begin
          fmt = FMT_I;
        end else begin
          case (ins[31:20])
            F12_ECALL:  d.exc[EXC_ECALL]  = 1'b1;
            F12_EBREAK: d.exc[EXC_EBREAK] = 1'b1;
            F12_MRET:   d.exc[EXC_MRET]   = 1'b1;
            default: begin
              d.cls              = '0;
              d.exc[EXC_ILLEGAL] = 1'b1;
            end
          endcase
        end
      end
      default: d.exc[EXC_ILLEGAL] = 1'b1;
    endcase
    case (fmt)
      FMT_I:   d.imm = {{20{ins[31]}}, ins[31:20]};
      FMT_S:   d.imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      FMT_B:   d.imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      FMT_U:   d.imm = {ins[31:12], 12'b0};
      FMT_J:   d.imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: d.imm = '0;
    endcase
    return d;
  endfunction

  logic [IWIDTH+PC_WIDTH-1:0] head_dat;
  logic [IWIDTH-1:0]          head_instr;
  logic [PC_WIDTH-1:0]        head_pc;
  logic                       q_full, q_empty;
  logic                       advance, pop, bubble;
  dec_t                       head_dec;

  logic                ce_q, flush_q, f7_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic [AWIDTH-1:0]   rs1_q, rs2_q, rd_q;
  logic [2:0]          f3_q;
  logic [DWIDTH-1:0]   imm_q;
  logic [10:0]         opc_q;
  logic [3:0]          exc_q;

  ds_instr_queue #(
    .WIDTH(IWIDTH + PC_WIDTH),
    .DEPTH(DEPTH)
  ) u_queue (
    .clk_i   (ds_clk),
    .rst_n_i (ds_rst),
    .push_i  (ds_i_ce),
    .pop_i   (pop),
    .flush_i (ds_i_flush),
    .wdat_i  ({ds_i_instr, ds_i_pc}),
    .rdat_o  (head_dat),
    .count_o (ds_o_count),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

  assign {head_instr, head_pc} = head_dat;
  assign head_dec = decode(head_instr[31:0]);

`ifdef DS_LOAD_USE_EN
  logic rs1_hit, rs2_hit;
  assign rs1_hit = (|(head_dec.cls & RS1_USERS)) && (AWIDTH'(head_instr[19:15]) == rd_q);
  assign rs2_hit = (|(head_dec.cls & RS2_USERS)) && (AWIDTH'(head_instr[24:20]) == rd_q);
  assign bubble  = ce_q && opc_q[CLS_LOAD] && (rd_q != '0) && (rs1_hit || rs2_hit);
`else
  assign bubble = 1'b0;
`endif

  assign advance = !ds_i_stall && !ds_i_flush && !bubble;
  assign pop     = advance && !q_empty;

  // A bubble or an empty queue clears ce but leaves the last decoded fields in place.
  always_ff @(posedge ds_clk or negedge ds_rst) begin
    if (!ds_rst) begin
      ce_q    <= 1'b0;
      flush_q <= 1'b0;
      pc_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      f3_q    <= '0;
      f7_q    <= 1'b0;
      imm_q   <= '0;
      opc_q   <= '0;
      exc_q   <= '0;
    end else begin
      flush_q <= ds_i_flush;
      if (ds_i_flush) begin
        ce_q <= 1'b0;
      end else if (!ds_i_stall) begin
        ce_q <= pop;
        if (pop) begin
          pc_q  <= head_pc;
          rs1_q <= AWIDTH'(head_instr[19:15]);
          rs2_q <= AWIDTH'(head_instr[24:20]);
          rd_q  <= AWIDTH'(head_instr[11:7]);
          f3_q  <= head_instr[14:12];
          f7_q  <= head_instr[30];
          imm_q <= DWIDTH'($signed(head_dec.imm));
          opc_q <= head_dec.cls;
          exc_q <= head_dec.exc;
        end
      end
    end
  end

  assign ds_o_stall      = q_full;
  assign ds_o_flush      = flush_q;
  assign ds_o_ce         = ce_q;
  assign ds_o_pc         = pc_q;
  assign ds_o_addr_rs1_p = rs1_q;
  assign ds_o_addr_rs2_p = rs2_q;
  assign ds_o_addr_rd_p  = rd_q;
  assign ds_o_funct3     = f3_q;
  assign ds_o_funct7_b5  = f7_q;
  assign ds_o_imm        = imm_q;
  assign ds_o_opcode     = opc_q;
  assign ds_o_exception  = exc_q;

endmodule

// File: tb/tb_decode_queue_stage.sv
// Bench for decode_queue_stage: directed decode table, queue/flush/interlock sequences,
// then randomized traffic against a queue-based reference model.
`timescale 1ns/1ps
module tb_decode_queue_stage;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ins = '0, pc = '0;
  logic        ce = 1'b0, stall = 1'b0, flush = 1'b0;

  logic        o_stall, o_flush, o_ce, o_f7;
  logic [31:0] o_pc, o_imm;
  logic [4:0]  o_rs1, o_rs2, o_rd;
  logic [2:0]  o_f3;
  logic [10:0] o_opc;
  logic [3:0]  o_exc;
  logic [2:0]  o_count;

  always #5 clk = ~clk;

  decode_queue_stage dut (
    .ds_clk(clk), .ds_rst(rst_n), .ds_i_instr(ins), .ds_i_pc(pc), .ds_i_ce(ce),
    .ds_i_stall(stall), .ds_i_flush(flush), .ds_o_stall(o_stall), .ds_o_flush(o_flush),
    .ds_o_ce(o_ce), .ds_o_pc(o_pc), .ds_o_addr_rs1_p(o_rs1), .ds_o_addr_rs2_p(o_rs2),
    .ds_o_addr_rd_p(o_rd), .ds_o_funct3(o_f3), .ds_o_funct7_b5(o_f7), .ds_o_imm(o_imm),
    .ds_o_opcode(o_opc), .ds_o_exception(o_exc), .ds_o_count(o_count)
  );

  int n_tests = 0, n_fail = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [10:0] cls;
    logic [3:0]  exc;
    logic [31:0] imm;
    logic [4:0]  rd, rs1, rs2;
  } vec_t;
  vec_t vecs[16];

  // Reference decode: class index from the opcode, immediates by signed arithmetic.
  typedef struct packed {
    logic [10:0] cls;
    logic [3:0]  exc;
    logic [31:0] imm;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic        f7;
  } ref_t;

  function automatic ref_t ref_decode(input logic [31:0] w);
    ref_t r;
    int   idx, imm, s;
    s = $signed(w);
    idx = -1; imm = 0;
    r.rd = w[11:7]; r.rs1 = w[19:15]; r.rs2 = w[24:20]; r.f3 = w[14:12]; r.f7 = w[30];
    r.cls = '0; r.exc = '0;
    case (w[6:0])
      7'h33: idx = 0;
      7'h13: begin idx = 1; imm = s >>> 20; end
      7'h03: begin idx = 2; imm = s >>> 20; end
      7'h23: begin idx = 3; imm = (s >>> 25) * 32 + int'(w[11:7]); end
      7'h63: begin idx = 4; imm = (w[31] ? -4096 : 0) + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2; end
      7'h6F: begin idx = 5; imm = (w[31] ? -1048576 : 0) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2; end
      7'h67: begin idx = 6; imm = s >>> 20; end
      7'h37: begin idx = 7; imm = s & ~4095; end
      7'h17: begin idx = 8; imm = s & ~4095; end
      7'h0F: idx = 10;
      7'h73: begin
        if (w[14:12] != 3'd0)        begin idx = 9; imm = s >>> 20; end
        else if (w[31:20] == 12'h000) begin idx = 9; r.exc = 4'b0010; end
        else if (w[31:20] == 12'h001) begin idx = 9; r.exc = 4'b0100; end
        else if (w[31:20] == 12'h302) begin idx = 9; r.exc = 4'b1000; end
        else r.exc = 4'b0001;
      end
      default: r.exc = 4'b0001;
    endcase
    if (idx >= 0) r.cls = 11'(1) << idx;
    r.imm = imm;
    return r;
  endfunction

  logic [63:0] mq[$];
  logic        m_ce, m_flush;
  logic [31:0] m_pc;
  ref_t        m_dec;

  function automatic bit load_use(input ref_t h);
    bit en, r1, r2;
`ifdef DS_LOAD_USE_EN
    en = 1'b1;
`else
    en = 1'b0;
`endif
    r1 = h.cls[0] || h.cls[1] || h.cls[2] || h.cls[3] || h.cls[4] || h.cls[6];
    r2 = h.cls[0] || h.cls[3] || h.cls[4];
    return en && m_ce && m_dec.cls[2] && (m_dec.rd != 0) &&
           ((r1 && h.rs1 == m_dec.rd) || (r2 && h.rs2 == m_dec.rd));
  endfunction

  task automatic model_step(input logic c, input logic st, input logic fl, input logic [31:0] w, input logic [31:0] p);
    bit can_push;
    can_push = c && (mq.size() < DEPTH);
    if (fl) begin
      mq.delete();
      m_ce = 1'b0;
    end else begin
      if (!st) begin
        if (mq.size() > 0 && !load_use(ref_decode(mq[0][63:32]))) begin
          m_dec = ref_decode(mq[0][63:32]);
          m_pc  = mq[0][31:0];
          void'(mq.pop_front());
          m_ce  = 1'b1;
        end else begin
          m_ce = 1'b0;
        end
      end
      if (can_push) mq.push_back({w, p});
    end
    m_flush = fl;
  endtask

  function automatic logic [127:0] dut_bundle();
    return {o_flush, o_stall, o_ce, o_count, o_pc, o_rd, o_rs1, o_rs2, o_f3, o_f7, o_imm, o_opc, o_exc};
  endfunction

  function automatic logic [127:0] exp_bundle();
    return {m_flush, (mq.size() == DEPTH), m_ce, 3'(mq.size()), m_pc, m_dec.rd, m_dec.rs1, m_dec.rs2,
            m_dec.f3, m_dec.f7, m_dec.imm, m_dec.cls, m_dec.exc};
  endfunction

  function automatic logic [31:0] rand_instr();
    case ($urandom_range(0, 5))
      0: return {12'($urandom_range(0, 15)), 5'($urandom_range(0, 3)), 3'b010, 5'($urandom_range(0, 3)), 7'h03};
      1: return {7'h00, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 3'b000, 5'($urandom_range(0, 3)), 7'h33};
      2: return {7'h00, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 3'b010, 5'd4, 7'h23};
      3: return {25'($urandom), 7'h63};
      4: return vecs[$urandom_range(0, 15)].instr;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    vecs[0]  = '{32'h00500093, 11'h002, 4'b0000, 32'h00000005, 5'd1,  5'd0,  5'd5};
    vecs[1]  = '{32'h00000073, 11'h200, 4'b0010, 32'h00000000, 5'd0,  5'd0,  5'd0};
    vecs[2]  = '{32'h00100073, 11'h200, 4'b0100, 32'h00000000, 5'd0,  5'd0,  5'd1};
    vecs[3]  = '{32'h30200073, 11'h200, 4'b1000, 32'h00000000, 5'd0,  5'd0,  5'd2};
    vecs[4]  = '{32'hFFFFFFFF, 11'h000, 4'b0001, 32'h00000000, 5'd31, 5'd31, 5'd31};
    vecs[5]  = '{32'hFE208EE3, 11'h010, 4'b0000, 32'hFFFFFFFC, 5'd29, 5'd1,  5'd2};
    vecs[6]  = '{32'h0000A283, 11'h004, 4'b0000, 32'h00000000, 5'd5,  5'd1,  5'd0};
    vecs[7]  = '{32'h00228333, 11'h001, 4'b0000, 32'h00000000, 5'd6,  5'd5,  5'd2};
    vecs[8]  = '{32'h12345037, 11'h080, 4'b0000, 32'h12345000, 5'd0,  5'd8,  5'd3};
    vecs[9]  = '{32'h0020A423, 11'h008, 4'b0000, 32'h00000008, 5'd8,  5'd1,  5'd2};
    vecs[10] = '{32'hFF5FF0EF, 11'h020, 4'b0000, 32'hFFFFFFF4, 5'd1,  5'd31, 5'd21};
    vecs[11] = '{32'h0FF0000F, 11'h400, 4'b0000, 32'h00000000, 5'd0,  5'd0,  5'd31};
    vecs[12] = '{32'h34029073, 11'h200, 4'b0000, 32'h00000340, 5'd0,  5'd5,  5'd0};
    vecs[13] = '{32'h00001517, 11'h100, 4'b0000, 32'h00001000, 5'd10, 5'd0,  5'd0};
    vecs[14] = '{32'h000080E7, 11'h040, 4'b0000, 32'h00000000, 5'd1,  5'd1,  5'd0};
    vecs[15] = '{32'h00500090, 11'h000, 4'b0001, 32'h00000000, 5'd1,  5'd0,  5'd5};

    // Reset held for two cycles.
    step(); step();
    check("reset_outputs", dut_bundle(), '0);
    rst_n = 1'b1;
    step();

    // Decode table: push one instruction, ce stays low one edge, then the decoded fields appear.
    for (int i = 0; i < 16; i++) begin
      ins = vecs[i].instr; pc = 32'(i * 4); ce = 1'b1;
      step();
      ce = 1'b0;
      check($sformatf("latency%0d", i), o_ce, 1'b0);
      step();
      check($sformatf("vec%0d", i), {o_ce, o_pc, o_opc, o_exc, o_imm, o_rd, o_rs1, o_rs2},
            {1'b1, 32'(i * 4), vecs[i].cls, vecs[i].exc, vecs[i].imm, vecs[i].rd, vecs[i].rs1, vecs[i].rs2});
    end

    // Fill under stall: 4th push raises ds_o_stall, 5th is dropped, outputs hold.
    stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      ins = 32'h00500093; pc = 32'(k * 4); ce = 1'b1;
      step();
      if (k == 2) check("fill3", {o_stall, o_count}, {1'b0, 3'd3});
      if (k == 3) check("fill4", {o_stall, o_count}, {1'b1, 3'd4});
    end
    ce = 1'b0;
    check("fill_drop", {o_stall, o_count, o_ce, o_pc}, {1'b1, 3'd4, 1'b1, 32'h3C});
    stall = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (k < 4) check($sformatf("drain%0d", k), {o_ce, o_pc}, {1'b1, 32'(k * 4)});
      else       check("drain_empty", {o_ce, o_count}, {1'b0, 3'd0});
    end

    // Load followed by a dependent add.
    ins = 32'h0000A283; pc = 32'h100; ce = 1'b1;
    step();
    ins = 32'h00228333; pc = 32'h104;
    step();
    ce = 1'b0;
    check("lu_load", {o_ce, o_pc}, {1'b1, 32'h100});
    step();
`ifdef DS_LOAD_USE_EN
    check("lu_bubble", {o_ce, o_count}, {1'b0, 3'd1});
    step();
`endif
    check("lu_add", {o_ce, o_pc, o_rd}, {1'b1, 32'h104, 5'd6});

    // Flush with three queued and a simultaneous push.
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      ins = 32'h00500093; pc = 32'(32'h200 + k * 4); ce = 1'b1;
      step();
    end
    check("pre_flush", o_count, 3'd3);
    flush = 1'b1;
    step();
    flush = 1'b0; ce = 1'b0; stall = 1'b0;
    check("flush", {o_count, o_ce, o_flush}, {3'd0, 1'b0, 1'b1});
    step();
    check("post_flush", {o_count, o_ce, o_flush}, {3'd0, 1'b0, 1'b0});

    // Asynchronous reset mid-operation.
    ins = 32'h00500093; pc = 32'h300; ce = 1'b1;
    step(); step();
    ce = 1'b0;
    check("pre_areset", {o_ce, o_count}, {1'b1, 3'd1});
    #2 rst_n = 1'b0;
    #1 check("areset", {o_ce, o_count, o_pc}, '0);
    step();
    rst_n = 1'b1;

    // Randomized traffic against the reference model.
    mq.delete(); m_ce = 1'b0; m_flush = 1'b0; m_pc = '0; m_dec = '0;
    for (int i = 0; i < 1500; i++) begin
      check($sformatf("rand%0d", i), dut_bundle(), exp_bundle());
      ins   = rand_instr();
      pc    = $urandom;
      ce    = ($urandom_range(0, 99) < 75);
      stall = ($urandom_range(0, 99) < 25);
      flush = ($urandom_range(0, 99) < 3);
      model_step(ce, stall, flush, ins, pc);
      step();
    end
    check("rand_end", dut_bundle(), exp_bundle());

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
